// File: rtl/pc_sequencer_if.sv
// Bus between the control unit and the PC sequencer: branch/jump/context
// controls from the control unit, PC and scheduler status back to it.
`timescale 1ns/1ps
interface pc_sequencer_if #(
    parameter int ADDR_W   = 32,
    parameter int IMM_W    = 11,
    parameter int NUM_PROC = 4,
    parameter int QUANTUM  = 16,
    parameter int PROC_W   = $clog2(NUM_PROC),
    parameter int Q_W      = $clog2(QUANTUM + 1)
);
    logic              halt_req;
    logic              resume;
    logic              branch_taken;
    logic              jump_en;
    logic              jump_reg;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] reg_target;
    logic              ctx_enable;
    logic              ctx_return;
    logic [PROC_W-1:0] proc_sel;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] saved_pc;
    logic [PROC_W-1:0] cur_proc;
    logic              in_sched;
    logic              halted;
    logic              preempt;
    logic [Q_W-1:0]    quantum_left;

    modport master (
        output halt_req, resume, branch_taken, jump_en, jump_reg, imm,
               reg_target, ctx_enable, ctx_return, proc_sel,
        input  pc, pc_plus1, saved_pc, cur_proc, in_sched, halted,
               preempt, quantum_left
    );

    modport slave (
        input  halt_req, resume, branch_taken, jump_en, jump_reg, imm,
               reg_target, ctx_enable, ctx_return, proc_sel,
        output pc, pc_plus1, saved_pc, cur_proc, in_sched, halted,
               preempt, quantum_left
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with branch/jump selection, per-process saved-PC bank,
// preemption quantum timer and halt/resume handling.
`timescale 1ns/1ps
module pc_sequencer #(
    parameter int          ADDR_W      = 32,
    parameter int          IMM_W       = 11,
    parameter int          NUM_PROC    = 4,
    parameter int          PROC_W      = $clog2(NUM_PROC),
    parameter int          QUANTUM     = 16,
    parameter int          Q_W         = $clog2(QUANTUM + 1),
    parameter int unsigned SCHED_ADDR  = 0,
    parameter int unsigned PROC_STRIDE = 256
) (
    input logic             clock,
    input logic             reset,
    pc_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {SCHED, RUN, HALT} state_t;

    state_t            state, state_n;
    logic              ret_sched, ret_sched_n;
    logic [ADDR_W-1:0] pc, pc_n, pc_inc, imm_target, target;
    logic [PROC_W-1:0] cur_proc, cur_proc_n;
    logic [Q_W-1:0]    quantum, quantum_n;
    logic              preempt, preempt_n;
    logic              slot_we;
    logic [ADDR_W-1:0] slot [NUM_PROC];

    assign pc_inc     = pc + ADDR_W'(1);
    assign imm_target = {pc[ADDR_W-1:IMM_W], bus.imm};
    assign target     = bus.jump_en      ? (bus.jump_reg ? bus.reg_target : imm_target) :
                        bus.branch_taken ? imm_target : pc_inc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= SCHED;
            ret_sched <= 1'b1;
            pc        <= ADDR_W'(SCHED_ADDR);
            cur_proc  <= '0;
            quantum   <= Q_W'(QUANTUM);
            preempt   <= 1'b0;
            for (int i = 0; i < NUM_PROC; i++)
                slot[i] <= ADDR_W'((i + 1) * PROC_STRIDE);
        end else begin
            state     <= state_n;
            ret_sched <= ret_sched_n;
            pc        <= pc_n;
            cur_proc  <= cur_proc_n;
            quantum   <= quantum_n;
            preempt   <= preempt_n;
            if (slot_we)
                slot[cur_proc] <= target;
        end
    end

    // halt_req outranks both dispatch and quantum expiry
    always_comb begin
        state_n     = state;
        ret_sched_n = ret_sched;
        pc_n        = pc;
        cur_proc_n  = cur_proc;
        quantum_n   = quantum;
        preempt_n   = 1'b0;
        slot_we     = 1'b0;
        case (state)
            SCHED: begin
                if (bus.halt_req) begin
                    state_n     = HALT;
                    ret_sched_n = 1'b1;
                end else if (bus.ctx_return) begin
                    pc_n       = slot[bus.proc_sel];
                    cur_proc_n = bus.proc_sel;
                    quantum_n  = Q_W'(QUANTUM);
                    state_n    = RUN;
                end else begin
                    pc_n = target;
                end
            end
            RUN: begin
                if (bus.halt_req) begin
                    state_n     = HALT;
                    ret_sched_n = 1'b0;
                end else if (bus.ctx_enable && quantum == Q_W'(1)) begin
                    slot_we   = 1'b1;
                    pc_n      = ADDR_W'(SCHED_ADDR);
                    quantum_n = Q_W'(QUANTUM);
                    preempt_n = 1'b1;
                    state_n   = SCHED;
                end else begin
                    pc_n = target;
                    if (bus.ctx_enable)
                        quantum_n = quantum - Q_W'(1);
                end
            end
            HALT: begin
                if (bus.resume) begin
                    pc_n    = pc_inc;
                    state_n = ret_sched ? SCHED : RUN;
                end
            end
            default: state_n = SCHED;
        endcase
    end

    assign bus.pc           = pc;
    assign bus.pc_plus1     = pc_inc;
    assign bus.saved_pc     = slot[bus.proc_sel];
    assign bus.cur_proc     = cur_proc;
    assign bus.in_sched     = (state == SCHED) || (state == HALT && ret_sched);
    assign bus.halted       = (state == HALT);
    assign bus.preempt      = preempt;
    assign bus.quantum_left = quantum;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with QUANTUM=4: dispatch, preemption,
// target priorities, halt/resume, simultaneous events and async reset.
`timescale 1ns/1ps
module tb_pc_sequencer;
    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if #(.QUANTUM(4)) bus ();

    pc_sequencer #(.QUANTUM(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.halt_req     = 1'b0;
        bus.resume       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jump_en      = 1'b0;
        bus.jump_reg     = 1'b0;
        bus.ctx_return   = 1'b0;
        bus.imm          = '0;
        bus.reg_target   = '0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        bus.ctx_enable = 1'b0;
        bus.proc_sel   = 2'd2;
        tick();
        tick();
        check_output("reset_pc", bus.pc, 32'h0);
        check_output("reset_in_sched", 32'(bus.in_sched), 32'd1);
        check_output("reset_cur_proc", 32'(bus.cur_proc), 32'd0);
        check_output("reset_quantum", 32'(bus.quantum_left), 32'd4);
        check_output("reset_slot2", bus.saved_pc, 32'd768);
        check_output("reset_halted", 32'(bus.halted), 32'd0);
        check_output("reset_preempt", 32'(bus.preempt), 32'd0);

        // Dispatch process 1, then run its four-instruction slice
        reset = 1'b1;
        bus.ctx_return = 1'b1;
        bus.proc_sel   = 2'd1;
        tick();
        check_output("dispatch_pc", bus.pc, 32'd512);
        check_output("dispatch_cur", 32'(bus.cur_proc), 32'd1);
        check_output("dispatch_in_sched", 32'(bus.in_sched), 32'd0);
        bus.ctx_return = 1'b0;
        bus.ctx_enable = 1'b1;
        tick();
        check_output("run_pc513", bus.pc, 32'd513);
        tick();
        check_output("run_pc514", bus.pc, 32'd514);
        tick();
        check_output("run_pc515", bus.pc, 32'd515);
        check_output("run_q1", 32'(bus.quantum_left), 32'd1);
        tick();
        check_output("preempt_pc", bus.pc, 32'd0);
        check_output("preempt_pulse", 32'(bus.preempt), 32'd1);
        check_output("preempt_in_sched", 32'(bus.in_sched), 32'd1);
        tick();
        check_output("preempt_drop", 32'(bus.preempt), 32'd0);
        check_output("saved_slot1", bus.saved_pc, 32'd516);

        // Halt in RUN, hold for 10 cycles, then resume
        bus.ctx_return = 1'b1;
        tick();
        bus.ctx_return = 1'b0;
        check_output("redispatch_pc", bus.pc, 32'd516);
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        check_output("halt_flag", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        check_output("halt_pc_held", bus.pc, 32'd516);
        check_output("halt_q_held", 32'(bus.quantum_left), 32'd4);
        check_output("halt_not_sched", 32'(bus.in_sched), 32'd0);
        bus.resume = 1'b1;
        tick();
        check_output("resume_pc", bus.pc, 32'd517);
        check_output("resume_halted", 32'(bus.halted), 32'd0);
        tick();
        bus.resume = 1'b0;
        check_output("resume_in_run_pc", bus.pc, 32'd518);
        check_output("resume_in_run_q", 32'(bus.quantum_left), 32'd3);
        check_output("resume_in_run_halted", 32'(bus.halted), 32'd0);

        // Target priorities with the quantum frozen
        bus.ctx_enable = 1'b0;
        bus.jump_en    = 1'b1;
        bus.jump_reg   = 1'b1;
        bus.reg_target = 32'h0000_0A05;
        tick();
        check_output("jreg_pc", bus.pc, 32'h0000_0A05);
        bus.jump_en      = 1'b0;
        bus.jump_reg     = 1'b0;
        bus.branch_taken = 1'b1;
        bus.imm          = 11'h7F3;
        tick();
        check_output("branch_pc", bus.pc, 32'h0000_0FF3);
        bus.jump_en    = 1'b1;
        bus.jump_reg   = 1'b1;
        bus.reg_target = 32'h0000_1234;
        tick();
        check_output("jump_over_branch", bus.pc, 32'h0000_1234);
        bus.branch_taken = 1'b0;
        bus.reg_target   = 32'hFFFF_FFFF;
        tick();
        check_output("pc_allones", bus.pc, 32'hFFFF_FFFF);
        check_output("plus1_wrap", bus.pc_plus1, 32'h0);
        clear_inputs();
        tick();
        check_output("seq_wrap", bus.pc, 32'h0);
        bus.jump_en = 1'b1;
        bus.imm     = 11'h055;
        tick();
        check_output("jump_imm", bus.pc, 32'h0000_0055);
        clear_inputs();
        for (int i = 0; i < 50; i++) tick();
        check_output("noctx_pc", bus.pc, 32'h0000_0087);
        check_output("noctx_q", 32'(bus.quantum_left), 32'd3);
        check_output("noctx_in_sched", 32'(bus.in_sched), 32'd0);

        // Expiry coinciding with an immediate jump saves the jump target
        bus.ctx_enable = 1'b1;
        tick();
        tick();
        check_output("pre_expiry_q", 32'(bus.quantum_left), 32'd1);
        bus.jump_en = 1'b1;
        bus.imm     = 11'h040;
        tick();
        clear_inputs();
        check_output("expiry_jump_pc", bus.pc, 32'h0);
        check_output("expiry_jump_preempt", 32'(bus.preempt), 32'd1);
        check_output("expiry_jump_slot", bus.saved_pc, 32'h0000_0040);
        check_output("expiry_q_reload", 32'(bus.quantum_left), 32'd4);

        // halt_req at expiry wins: no preempt, quantum stays at 1
        bus.ctx_return = 1'b1;
        tick();
        bus.ctx_return = 1'b0;
        check_output("dispatch_jumped_slot", bus.pc, 32'h0000_0040);
        tick();
        tick();
        tick();
        check_output("halt_setup_pc", bus.pc, 32'h0000_0043);
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        check_output("halt_expiry_halted", 32'(bus.halted), 32'd1);
        check_output("halt_expiry_preempt", 32'(bus.preempt), 32'd0);
        check_output("halt_expiry_q", 32'(bus.quantum_left), 32'd1);
        check_output("halt_expiry_pc", bus.pc, 32'h0000_0043);
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        check_output("resume_run_pc", bus.pc, 32'h0000_0044);
        tick();
        check_output("late_expiry_pc", bus.pc, 32'h0);
        check_output("late_expiry_slot", bus.saved_pc, 32'h0000_0045);

        // Halt from SCHED keeps in_sched and returns to SCHED
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        check_output("sched_halt_halted", 32'(bus.halted), 32'd1);
        check_output("sched_halt_in_sched", 32'(bus.in_sched), 32'd1);
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        check_output("sched_resume_pc", bus.pc, 32'h1);
        check_output("sched_resume_in_sched", 32'(bus.in_sched), 32'd1);

        // ctx_return is ignored while running
        bus.ctx_return = 1'b1;
        bus.proc_sel   = 2'd2;
        tick();
        check_output("dispatch2_pc", bus.pc, 32'd768);
        bus.proc_sel = 2'd0;
        tick();
        bus.ctx_return = 1'b0;
        check_output("ignored_ret_pc", bus.pc, 32'd769);
        check_output("ignored_ret_cur", 32'(bus.cur_proc), 32'd2);

        // Asynchronous reset mid-RUN acts before the next edge
        bus.jump_en    = 1'b1;
        bus.jump_reg   = 1'b1;
        bus.reg_target = 32'd600;
        tick();
        clear_inputs();
        check_output("pre_reset_pc", bus.pc, 32'd600);
        bus.proc_sel = 2'd1;
        reset = 1'b0;
        #1;
        check_output("async_reset_pc", bus.pc, 32'h0);
        check_output("async_reset_cur", 32'(bus.cur_proc), 32'd0);
        check_output("async_reset_in_sched", 32'(bus.in_sched), 32'd1);
        check_output("async_reset_slot1", bus.saved_pc, 32'd512);
        check_output("async_reset_q", 32'(bus.quantum_left), 32'd4);
        tick();
        reset = 1'b1;
        tick();
        check_output("release_pc", bus.pc, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
